i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 Param BUF_CYCLES, default 140: bus-free hold-off after a release, in clocks (about 4.9 us at 28 MHz).
REQ-002 Param IDLE_CYCLES, default 16: clocks SCL and SDA must both stay high before the bus counts as idle.
REQ-003 Param TIMEOUT_CYCLES, default 700000: watchdog limit in clocks for SCL held low while granted (about 25 ms).
REQ-004 clk  in  1  system clock (clk_28 domain); this is the only clock.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 m0_req, m1_req  in  1 each  master requests bus ownership (m0 = Minimig I2C, m1 = config sender).
REQ-007 m0_gnt, m1_gnt  out  1 each  ownership granted to that master.
REQ-008 m0_scl_t, m0_sda_t, m1_scl_t, m1_sda_t  in  1 each  master drive enables; 0 = pull low, 1 = release.
REQ-009 m0_scl_i, m0_sda_i, m1_scl_i, m1_sda_i  out  1 each  bus view returned to each master.
REQ-010 bus_scl_i, bus_sda_i  in  1 each  raw asynchronous pad levels.
REQ-011 bus_scl_t, bus_sda_t  out  1 each  pad drive enables; 0 = pull low.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 timeout  out  1  one-clock pulse when the watchdog fires.

Function
REQ-014 Pad inputs SHALL pass through 2-FF synchronizers; all logic uses the synchronized scl_s and sda_s.
REQ-015 START SHALL be detected as sda_s falling while scl_s = 1, and STOP as sda_s rising while scl_s = 1, each from registered previous values.
REQ-016 The idle counter SHALL count while scl_s and sda_s are both 1, clear on any 0, and saturate at IDLE_CYCLES; bus_idle = (count == IDLE_CYCLES).
REQ-017 States SHALL be IDLE, OWN0, OWN1, WAIT_STOP and HOLDOFF.
REQ-018 In IDLE with bus_idle and one request pending, the arbiter SHALL go to the matching OWN state on the next clock and assert that gnt.
REQ-019 In IDLE with both requests pending, the arbiter SHALL grant by round-robin: the master not granted last wins; after reset the pointer favours m0.
REQ-020 In OWNx, bus_scl_t/bus_sda_t SHALL equal mx_scl_t/mx_sda_t combinationally, and the other master's t inputs SHALL be ignored.
REQ-021 The granted master's scl_i/sda_i SHALL be scl_s/sda_s.
REQ-022 A non-granted master SHALL see scl_i = 0 (clock stretch) and sda_i = sda_s.
REQ-023 In IDLE, WAIT_STOP and HOLDOFF, bus_scl_t and bus_sda_t SHALL be 1, and both masters SHALL see scl_i = 0.
REQ-024 When mx_req falls in OWNx, gnt SHALL drop the same clock and the state SHALL become WAIT_STOP.
REQ-025 WAIT_STOP SHALL go to HOLDOFF on a detected STOP or on bus_idle, whichever comes first.
REQ-026 HOLDOFF SHALL count BUF_CYCLES clocks, then return to IDLE; a START seen during HOLDOFF (external master) SHALL restart the count.
REQ-027 In OWNx, a watchdog SHALL count clocks with scl_s = 0 and clear when scl_s = 1.
REQ-028 When the watchdog reaches TIMEOUT_CYCLES, the arbiter SHALL drop gnt, release the bus, pulse timeout for one clock, enter HOLDOFF, and set the round-robin pointer to the other master.
REQ-029 A new request in the same clock as a release SHALL NOT be granted before HOLDOFF completes.
REQ-030 A request asserted and then withdrawn in IDLE before bus_idle SHALL have no effect.
REQ-031 Counter widths SHALL be $clog2(param+1); counters SHALL saturate, never wrap.

Reset
REQ-032 On rst, the state SHALL go to IDLE and all counters to 0.
REQ-033 On rst, m0_gnt, m1_gnt, busy and timeout SHALL be 0, bus_scl_t and bus_sda_t SHALL be 1, and the RR pointer SHALL favour m0.
REQ-034 On rst, the synchronizer flops SHALL be set to 1.
REQ-035 A reset mid-transfer SHALL release the pads on the first clock edge with rst high; the arbiter does not generate a STOP.

Structure
REQ-036 Package i2c_arb_pkg SHALL hold the state encoding and the default BUF/IDLE/TIMEOUT constants.
REQ-037 One sub-module, i2c_bus_monitor, SHALL contain the synchronizers, START/STOP detection and the idle counter, and output scl_s, sda_s, start, stop and bus_idle.

Verification
REQ-038 Idle bus, m1_req rises -> m1_gnt = 1 at 16+1 clocks after the bus is high; m1 drives SDA low -> bus_sda_t = 0 the same cycle; m0_scl_i = 0 throughout.
REQ-039 m0_req and m1_req rise together from reset -> m0 is granted; after release, STOP and 140 clocks, both request again -> m1 is granted.
REQ-040 m0 drops req, then issues STOP 30 clocks later -> state goes WAIT_STOP, then HOLDOFF at the STOP, and IDLE exactly 140 clocks after.
REQ-041 Granted master holds SCL low for 700000 clocks -> timeout pulse of width 1, gnt = 0, bus_scl_t = 1 the same clock, and the other master is granted next.
REQ-042 External START injected during HOLDOFF at count 100 -> HOLDOFF restarts, and IDLE is reached 140 clocks after the START.
REQ-043 rst asserted while m0 drives SDA low mid-byte -> next edge gives bus_sda_t = 1, gnt = 0 and busy = 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared constants for the two-master I2C bus arbiter.
// Holds the FSM state encoding and the default timing constants, expressed in
// clk_28 cycles.
package i2c_arb_pkg;

    // Default timing, in 28 MHz clocks
    localparam int unsigned DefBufCycles     = 140;    // ~4.9 us bus-free time
    localparam int unsigned DefIdleCycles    = 16;     // SCL/SDA high before bus is idle
    localparam int unsigned DefTimeoutCycles = 700000; // ~25 ms SCL-low watchdog

    // Arbiter FSM encoding
    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StOwn0     = 3'd1;
    localparam logic [2:0] StOwn1     = 3'd2;
    localparam logic [2:0] StWaitStop = 3'd3;
    localparam logic [2:0] StHoldoff  = 3'd4;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Bus observer for the I2C arbiter.
// Synchronizes the raw pad levels and derives START/STOP events and an
// idle indication.
//   clk, rst             : system clock, synchronous active-high reset
//   bus_scl_i, bus_sda_i : raw asynchronous pad levels
//   scl_s, sda_s         : synchronized levels
//   start, stop          : single-cycle START / STOP conditions
//   bus_idle             : both lines high for IDLE_CYCLES clocks
module i2c_bus_monitor
    import i2c_arb_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = DefIdleCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic bus_scl_i,
    input  logic bus_sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic start,
    output logic stop,
    output logic bus_idle
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);

    logic [1:0]    scl_sync_q, sda_sync_q;
    logic          scl_prev_q, sda_prev_q;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    // SDA edges are only conditions while SCL is high on both samples
    assign start = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
    assign stop  = scl_prev_q & scl_s & ~sda_prev_q & sda_s;

    assign bus_idle = (idle_cnt_q == IW'(IDLE_CYCLES));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!(scl_s && sda_s)) begin
            idle_cnt_d = '0;
        end else if (!bus_idle) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end
    end

    // Sync flops reset to 1 so a reset never looks like a bus event
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            idle_cnt_q <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus_scl_i};
            sda_sync_q <= {sda_sync_q[0], bus_sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Two-master I2C bus arbiter (m0 = Minimig I2C, m1 = config sender).
// Grants the shared pads to one master at a time, round-robin on contention,
// enforces a bus-free hold-off after each release and a SCL-low watchdog.
//   clk, rst                  : system clock, synchronous active-high reset
//   mX_req / mX_gnt           : ownership request / grant per master
//   mX_scl_t, mX_sda_t        : master drive enables (0 = pull low)
//   mX_scl_i, mX_sda_i        : bus view returned to each master
//   bus_scl_i, bus_sda_i      : raw pad levels
//   bus_scl_t, bus_sda_t      : pad drive enables (0 = pull low)
//   busy                      : arbiter not idle
//   timeout                   : one-clock pulse when the watchdog fires
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned BUF_CYCLES     = DefBufCycles,
    parameter int unsigned IDLE_CYCLES    = DefIdleCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_gnt,
    output logic m1_gnt,
    input  logic m0_scl_t,
    input  logic m0_sda_t,
    input  logic m1_scl_t,
    input  logic m1_sda_t,
    output logic m0_scl_i,
    output logic m0_sda_i,
    output logic m1_scl_i,
    output logic m1_sda_i,
    input  logic bus_scl_i,
    input  logic bus_sda_i,
    output logic bus_scl_t,
    output logic bus_sda_t,
    output logic busy,
    output logic timeout
);

    localparam int unsigned HW = $clog2(BUF_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    logic          scl_s, sda_s, start, stop, bus_idle;
    logic [2:0]    state_q, state_d;
    logic          rr_q, rr_d;   // 1 = m1 wins the next tie
    logic [HW-1:0] hold_q, hold_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          owning, timeout_hit;

    i2c_bus_monitor #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_monitor (
        .clk       (clk),
        .rst       (rst),
        .bus_scl_i (bus_scl_i),
        .bus_sda_i (bus_sda_i),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .start     (start),
        .stop      (stop),
        .bus_idle  (bus_idle)
    );

    assign owning      = (state_q == StOwn0) || (state_q == StOwn1);
    assign timeout_hit = owning && (wd_q == WW'(TIMEOUT_CYCLES));

    // Grants drop combinationally on req release or watchdog expiry
    assign m0_gnt = (state_q == StOwn0) && m0_req && !timeout_hit;
    assign m1_gnt = (state_q == StOwn1) && m1_req && !timeout_hit;

    assign bus_scl_t = m0_gnt ? m0_scl_t : (m1_gnt ? m1_scl_t : 1'b1);
    assign bus_sda_t = m0_gnt ? m0_sda_t : (m1_gnt ? m1_sda_t : 1'b1);

    // Non-owners are held in a clock stretch but still see SDA
    assign m0_scl_i = m0_gnt & scl_s;
    assign m1_scl_i = m1_gnt & scl_s;
    assign m0_sda_i = sda_s;
    assign m1_sda_i = sda_s;

    assign busy    = (state_q != StIdle);
    assign timeout = timeout_hit;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        wd_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (bus_idle) begin
                    if (m0_req && (!m1_req || !rr_q)) begin
                        state_d = StOwn0;
                        rr_d    = 1'b1;
                    end else if (m1_req) begin
                        state_d = StOwn1;
                        rr_d    = 1'b0;
                    end
                end
            end
            StOwn0, StOwn1: begin
                if (timeout_hit) begin
                    state_d = StHoldoff;
                    hold_d  = '0;
                    rr_d    = (state_q == StOwn0);
                end else if (!((state_q == StOwn0) ? m0_req : m1_req)) begin
                    state_d = StWaitStop;
                end else if (!scl_s) begin
                    wd_d = wd_q + WW'(1);
                end
            end
            StWaitStop: begin
                if (stop || bus_idle) begin
                    state_d = StHoldoff;
                    hold_d  = '0;
                end
            end
            StHoldoff: begin
                // An external START restarts the bus-free interval
                if (start) begin
                    hold_d = '0;
                end else if (32'(hold_q) + 32'd1 >= BUF_CYCLES) begin
                    state_d = StIdle;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            hold_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter.
// Grant events are checked through a scoreboard queue; the pads are modelled
// as wired-AND of the arbiter drive and an external agent.
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int unsigned BUF  = 140;
    localparam int unsigned IDLE = 16;
    localparam int unsigned TMO  = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m0_req = 1'b0, m1_req = 1'b0;
    logic m0_gnt, m1_gnt;
    logic m0_scl_t = 1'b1, m0_sda_t = 1'b1, m1_scl_t = 1'b1, m1_sda_t = 1'b1;
    logic m0_scl_i, m0_sda_i, m1_scl_i, m1_sda_i;
    logic bus_scl_i, bus_sda_i, bus_scl_t, bus_sda_t;
    logic busy, timeout;
    logic ext_scl = 1'b1, ext_sda = 1'b1;

    assign bus_scl_i = bus_scl_t & ext_scl;
    assign bus_sda_i = bus_sda_t & ext_sda;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .BUF_CYCLES     (BUF),
        .IDLE_CYCLES    (IDLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_scl_t  (m0_scl_t),
        .m0_sda_t  (m0_sda_t),
        .m1_scl_t  (m1_scl_t),
        .m1_sda_t  (m1_sda_t),
        .m0_scl_i  (m0_scl_i),
        .m0_sda_i  (m0_sda_i),
        .m1_scl_i  (m1_scl_i),
        .m1_sda_i  (m1_sda_i),
        .bus_scl_i (bus_scl_i),
        .bus_sda_i (bus_sda_i),
        .bus_scl_t (bus_scl_t),
        .bus_sda_t (bus_sda_t),
        .busy      (busy),
        .timeout   (timeout)
    );

    typedef struct {
        string      tag;
        logic [1:0] gnt;   // {m1_gnt, m0_gnt}
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] gnt);
        exp_t e;
        e.tag = tag;
        e.gnt = gnt;
        sb.push_back(e);
    endtask

    // Wait for any grant, then pop the expected pattern and compare
    task automatic wait_grant(input int budget, output int n);
        exp_t e;
        n = 0;
        while (!(m0_gnt || m1_gnt) && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            e.tag = "scoreboard_empty";
            e.gnt = 2'b11;
        end else begin
            e = sb.pop_front();
        end
        check(e.tag, 32'({m1_gnt, m0_gnt}), 32'(e.gnt));
    endtask

    task automatic count_until_state(input logic [2:0] st, input int budget, output int n,
                                     output logic saw_gnt);
        n       = 0;
        saw_gnt = 1'b0;
        while (dut.state_q !== st && n < budget) begin
            tick();
            n++;
            saw_gnt |= (m0_gnt | m1_gnt);
        end
    endtask

    initial begin
        int   n;
        logic saw;

        // Reset state
        repeat (3) tick();
        check("rst_m0_gnt", 32'(m0_gnt), 0);
        check("rst_m1_gnt", 32'(m1_gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_bus_t", 32'({bus_scl_t, bus_sda_t}), 32'h3);
        check("rst_scl_i", 32'({m1_scl_i, m0_scl_i}), 0);
        rst = 1'b0;

        // Short request withdrawn before the bus counts as idle
        m0_req = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            tick();
            saw |= m0_gnt | m1_gnt;
        end
        m0_req = 1'b0;
        repeat (30) begin
            tick();
            saw |= m0_gnt | m1_gnt;
        end
        check("withdrawn_no_gnt", 32'(saw), 0);
        check("withdrawn_busy", 32'(busy), 0);

        // Single request on idle bus: grant after IDLE+1 clocks
        rst = 1'b1;
        m1_req = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("m1_single_grant", 2'b10);
        wait_grant(100, n);
        check("m1_grant_latency", 32'(n), IDLE + 1);
        m1_sda_t = 1'b0;
        #1;
        check("m1_sda_pass", 32'(bus_sda_t), 0);
        m0_scl_t = 1'b0;
        m0_sda_t = 1'b0;
        #1;
        check("m0_t_ignored", 32'({bus_scl_t, bus_sda_t}), 32'h2);
        m0_scl_t = 1'b1;
        m0_sda_t = 1'b1;
        check("owner_scl_view", 32'({m1_scl_i, m0_scl_i}), 32'h2);
        repeat (3) tick();
        check("sda_view_both", 32'({m1_sda_i, m0_sda_i}), 0);
        m1_sda_t = 1'b1;
        m1_req = 1'b0;
        #1;
        check("m1_drop_same_clk", 32'(m1_gnt), 0);
        count_until_state(StIdle, 300, n, saw);
        check("m1_release_idle", 32'(busy), 0);

        // Tie from reset favours m0
        rst = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("tie_after_reset_m0", 2'b01);
        wait_grant(100, n);
        check("tie_latency", 32'(n), IDLE + 1);
        m0_sda_t = 1'b0;
        repeat (5) tick();
        // Release while an external agent keeps SDA low, STOP 30 clocks later
        m0_req = 1'b0;
        m0_sda_t = 1'b1;
        ext_sda = 1'b0;
        #1;
        check("m0_drop_same_clk", 32'(m0_gnt), 0);
        check("m0_drop_bus_rel", 32'(bus_sda_t), 1);
        tick();
        check("enter_wait_stop", 32'(dut.state_q), 32'(StWaitStop));
        repeat (30) tick();
        check("hold_wait_stop", 32'(dut.state_q), 32'(StWaitStop));
        ext_sda = 1'b1;
        tick();
        tick();
        check("stop_sync_delay", 32'(dut.state_q), 32'(StWaitStop));
        tick();
        check("stop_to_holdoff", 32'(dut.state_q), 32'(StHoldoff));
        m0_req = 1'b1;
        count_until_state(StIdle, 300, n, saw);
        check("holdoff_length", 32'(n), BUF);
        check("holdoff_no_gnt", 32'(saw), 0);
        expect_grant("rr_second_m1", 2'b10);
        wait_grant(10, n);
        check("rr_second_latency", 32'(n), 1);

        // Watchdog: m1 holds SCL low
        m1_scl_t = 1'b0;
        n = 0;
        while (!timeout && n < int'(TMO) + 50) begin
            tick();
            n++;
        end
        check("timeout_latency", 32'(n), TMO + 2);
        check("timeout_gnt_drop", 32'(m1_gnt), 0);
        check("timeout_scl_rel", 32'(bus_scl_t), 1);
        expect_grant("after_timeout_m0", 2'b01);
        tick();
        check("timeout_width", 32'(timeout), 0);
        check("timeout_holdoff", 32'(dut.state_q), 32'(StHoldoff));
        m1_scl_t = 1'b1;
        wait_grant(400, n);

        // External START during hold-off restarts the bus-free count
        m1_req = 1'b0;
        m0_req = 1'b0;
        #1;
        check("m0_drop2", 32'(m0_gnt), 0);
        tick();
        check("wait_stop2", 32'(dut.state_q), 32'(StWaitStop));
        tick();
        check("idle_to_holdoff", 32'(dut.state_q), 32'(StHoldoff));
        repeat (100) tick();
        ext_sda = 1'b0;
        count_until_state(StIdle, 300, n, saw);
        check("start_restart", 32'(n), BUF + 3);
        ext_sda = 1'b1;

        // Reset mid-transfer releases the pads at once
        m0_req = 1'b1;
        expect_grant("pre_reset_m0", 2'b01);
        wait_grant(100, n);
        m0_sda_t = 1'b0;
        #1;
        check("m0_sda_drive", 32'(bus_sda_t), 0);
        rst = 1'b1;
        tick();
        check("rst_mid_sda", 32'(bus_sda_t), 1);
        check("rst_mid_gnt", 32'(m0_gnt), 0);
        check("rst_mid_busy", 32'(busy), 0);
        rst = 1'b0;
        m0_req = 1'b0;
        m0_sda_t = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
